// File: rtl/clk_freq_mon.sv
// Divided-clock period monitor: samples mon_clk_i in the clk domain, measures the
// rise-to-rise period in clk cycles and flags out-of-tolerance periods or a stalled clock.
module clk_freq_mon #(
   parameter int              CNT_W    = 16,
   parameter int              SYNC_STG = 2,
   parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mon_clk_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] exp_period_i,
   input  logic [CNT_W-1:0] tol_i,
   output logic [CNT_W-1:0] period_o,
   output logic             period_vld_o,
   output logic             err_o,
   output logic             lost_o,
   output logic [7:0]       err_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SYNC_STG-1:0] sync_q;
   logic               prev_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic               vld_q, vld_d;
   logic               err_q, err_d;
   logic               lost_q, lost_d;
   logic [7:0]         err_cnt_q, err_cnt_d;
   logic               rise_s;
   logic               report_s;
   logic               lost_ev_s;
   logic [7:0]         err_cnt_base_s;
   logic [CNT_W:0]     diff_s;

   function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      if (a >= b) begin
         return {1'b0, a} - {1'b0, b};
      end else begin
         return {1'b0, b} - {1'b0, a};
      end
   endfunction

   assign rise_s = sync_q[SYNC_STG-1] & ~prev_q;
   assign diff_s = abs_diff(cnt_q, exp_period_i);

   // Synchronizer chain and edge-detect flop run regardless of FSM state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STG-2:0], mon_clk_i};
         prev_q <= sync_q[SYNC_STG-1];
      end
   end

   // FSM next state and counter
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      report_s  = 1'b0;
      lost_ev_s = 1'b0;
      if (!en_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARM;
               cnt_d   = '0;
            end
            ST_ARM: begin
               if (rise_s) begin
                  state_d = ST_MEAS;
                  cnt_d   = CNT_W'(1);
               end else if (cnt_q == TIMEOUT) begin
                  lost_ev_s = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_MEAS: begin
               if (rise_s) begin
                  report_s = 1'b1;
                  cnt_d    = CNT_W'(1);
               end else if (cnt_q == TIMEOUT) begin
                  lost_ev_s = 1'b1;
                  state_d   = ST_ARM;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Result and sticky status; a new event in the same cycle as clr_i wins
   always_comb begin
      period_d       = period_q;
      vld_d          = 1'b0;
      err_d          = err_q;
      lost_d         = lost_q;
      err_cnt_base_s = err_cnt_q;
      if (clr_i) begin
         err_d          = 1'b0;
         lost_d         = 1'b0;
         err_cnt_base_s = 8'h00;
      end else begin
         err_cnt_base_s = err_cnt_q;
      end
      err_cnt_d = err_cnt_base_s;
      if (report_s) begin
         period_d = cnt_q;
         vld_d    = 1'b1;
         if (diff_s > {1'b0, tol_i}) begin
            err_d = 1'b1;
            if (err_cnt_base_s == 8'hFF) begin
               err_cnt_d = 8'hFF;
            end else begin
               err_cnt_d = err_cnt_base_s + 8'd1;
            end
         end else begin
            err_cnt_d = err_cnt_base_s;
         end
      end else begin
         period_d = period_q;
      end
      if (lost_ev_s) begin
         lost_d = 1'b1;
      end else begin
         lost_d = lost_d;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
         lost_q    <= 1'b0;
         err_cnt_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
         lost_q    <= lost_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign period_o     = period_q;
   assign period_vld_o = vld_q;
   assign err_o        = err_q;
   assign lost_o       = lost_q;
   assign err_cnt_o    = err_cnt_q;

endmodule
